pc_control: RTL
===============

# pc_control

Next-PC and pipeline-control unit that drives `programCounter`. It resolves branches and jumps in the MEM stage and produces the redirect pair `BRANCHTAKEN_MEM`/`PC_N` plus `PCWrite`. It detects load-use hazards and inserts a configurable number of bubbles, and redirects misaligned targets to a trap vector. It also keeps taken-redirect and stall-cycle counters.

## Interface
- `LOAD_LATENCY`, default 1: bubbles per load-use hazard, legal range 1..7.
- `TRAP_VECTOR`, default 32'h0000_0100: redirect address for a misaligned target.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `BRANCH_MEM`, `JAL_MEM`, `JALR_MEM` in 1 each: control-transfer type of the instruction in MEM; at most one is set.
- `FUNCT3_MEM` in 3: branch condition.
- `PC_MEM`, `IMM_MEM`, `RS1VAL_MEM`, `RS2VAL_MEM` in 32 each: MEM-stage PC, immediate and forwarded operands.
- `MEMREAD_EX` in 1: the instruction in EX is a load.
- `RD_EX` in 5: destination register of that load.
- `RS1_ID`, `RS2_ID` in 5 each; `USES_RS1_ID`, `USES_RS2_ID` in 1 each: source registers of the ID instruction and whether each is read.
- `PCWrite` out 1: PC advance enable.
- `BRANCHTAKEN_MEM` out 1: redirect select.
- `PC_N` out 32: redirect target.
- `IFID_WRITE` out 1: IF/ID register enable.
- `IFID_FLUSH`, `IDEX_FLUSH`, `EXMEM_FLUSH` out 1 each: bubble insertion into each pipeline register.
- `TRAP` out 1: registered one-cycle pulse.
- `BADADDR` out 32: last misaligned target.
- `BRANCH_CNT`, `STALL_CNT` out 32 each: event counters.

## Operation
- Condition, evaluated only when `BRANCH_MEM`=1, by `FUNCT3_MEM`:
  - 000 beq: operands equal.
  - 001 bne: operands not equal.
  - 100 blt: signed less-than.
  - 101 bge: signed greater-or-equal.
  - 110 bltu: unsigned less-than.
  - 111 bgeu: unsigned greater-or-equal.
  - 010 and 011: never taken.
- `take` = (`BRANCH_MEM` and condition) or `JAL_MEM` or `JALR_MEM`.
- Raw target:
  - Branch or JAL: `PC_MEM`+`IMM_MEM`.
  - JALR: (`RS1VAL_MEM`+`IMM_MEM`) with bit0 cleared.
  - All additions mod 2^32.
- Misaligned: `take` and raw target bit1 = 1.
- Redirect (`take`=1):
  - `BRANCHTAKEN_MEM`=1 and `PCWrite`=1.
  - `PC_N` = `TRAP_VECTOR` if misaligned, else raw target.
  - `IFID_FLUSH`, `IDEX_FLUSH` and `EXMEM_FLUSH` = 1.
  - `IFID_WRITE`=1.
- Load-use hazard `lu` = `MEMREAD_EX` and `RD_EX`≠0 and ((`USES_RS1_ID` and `RS1_ID`=`RD_EX`) or (`USES_RS2_ID` and `RS2_ID`=`RD_EX`)).
- FSM states are RUN and STALL, with a 3-bit down-counter `cnt`.
  - In RUN with `lu` and no `take`: stall this cycle. If `LOAD_LATENCY`>1, go to STALL with `cnt`=`LOAD_LATENCY`-1; else stay in RUN.
  - In STALL: stall unconditionally (`lu` is ignored). `cnt` decrements each cycle; go to RUN on the cycle `cnt`=1.
  - A stall cycle means `PCWrite`=0, `IFID_WRITE`=0, `IDEX_FLUSH`=1, `BRANCHTAKEN_MEM`=0, and all other flushes 0.
- Priority: redirect over stall. A `take` in any state forces RUN, `cnt`=0, and the redirect outputs.
- Idle (no `take`, no stall): `PCWrite`=1, `IFID_WRITE`=1, all flushes 0, `BRANCHTAKEN_MEM`=0, `PC_N`=raw target.
- Counters:
  - `BRANCH_CNT` increments on every redirect cycle, misaligned ones included.
  - `STALL_CNT` increments on every stall cycle.
  - Both wrap from 32'hFFFF_FFFF to 0.
- Misaligned redirect: `TRAP`=1 on the next cycle; `BADADDR` loads the raw target.

## Timing
- `PCWrite`, `BRANCHTAKEN_MEM`, `PC_N`, `IFID_WRITE` and the flushes are combinational from the inputs and state, valid in the same cycle. `programCounter` consumes them at that cycle's edge.
- The redirect penalty is 3 squashed instructions, with zero extra latency inside this block.
- A load-use hazard gives exactly `LOAD_LATENCY` consecutive stall cycles, starting in the cycle `lu` is first seen.
- `TRAP`, `BADADDR`, counters, state and `cnt` are registered and update on the rising edge.
- Reset, asserted at any time including mid-stall:
  - State goes to RUN, `cnt`=0.
  - `TRAP`=0, `BADADDR`=0, `BRANCH_CNT`=0, `STALL_CNT`=0.
  - Any stall in progress is abandoned.
- With all inputs at 0: `PCWrite`=1, `IFID_WRITE`=1, every other output 0 except `PC_N`, which equals the raw target (0).

## Test plan
- beq, operands 5 and 5, `PC_MEM`=0x40, `IMM_MEM`=0x10 -> same cycle `BRANCHTAKEN_MEM`=1, `PC_N`=0x50, three flushes=1; `BRANCH_CNT`=1 next cycle.
- blt -1 vs 1 -> taken; bltu 0xFFFF_FFFF vs 1 -> not taken, `PCWrite`=1, no flush. Funct3 010 never taken.
- JALR with `RS1VAL_MEM`=0x103, `IMM_MEM`=0 -> `PC_N`=0x102, misaligned -> `PC_N`=0x100. Next cycle `TRAP`=1 for exactly one cycle, `BADADDR`=0x102.
- `LOAD_LATENCY`=3, load x5 in EX and ID reads x5 -> `PCWrite`=0 for exactly 3 cycles, `IDEX_FLUSH`=1 in each, `STALL_CNT`=3. With `RD_EX`=0 -> no stall.
- Stall in progress with `cnt`=2, then a jal in MEM -> same cycle redirect with `PCWrite`=1, state RUN, no further stall cycles.
- Reset pulse mid-STALL with `BRANCH_CNT`=7 -> counters 0, `PCWrite`=1 immediately after release; a preset `BRANCH_CNT`=0xFFFF_FFFF wraps to 0 on the next redirect.

Source files
------------

// File: rtl/pc_control.sv
// Next-PC selection and pipeline control: MEM-stage branch/jump resolution,
// load-use bubble insertion, misaligned-target trapping and event counters.
module pc_control #(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BRANCH_MEM,
  input  logic        JAL_MEM,
  input  logic        JALR_MEM,
  input  logic [2:0]  FUNCT3_MEM,
  input  logic [31:0] PC_MEM,
  input  logic [31:0] IMM_MEM,
  input  logic [31:0] RS1VAL_MEM,
  input  logic [31:0] RS2VAL_MEM,
  input  logic        MEMREAD_EX,
  input  logic [4:0]  RD_EX,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  input  logic        USES_RS1_ID,
  input  logic        USES_RS2_ID,
  output logic        PCWrite,
  output logic        BRANCHTAKEN_MEM,
  output logic [31:0] PC_N,
  output logic        IFID_WRITE,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic        EXMEM_FLUSH,
  output logic        TRAP,
  output logic [31:0] BADADDR,
  output logic [31:0] BRANCH_CNT,
  output logic [31:0] STALL_CNT
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LATENCY - 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        cond, take, lu, misaligned, stall;
  logic [31:0] raw_target, jalr_sum;
  logic [31:0] branch_cnt_q, stall_cnt_q;

  always_comb begin
    cond = 1'b0;
    case (FUNCT3_MEM)
      3'b000:  cond = (RS1VAL_MEM == RS2VAL_MEM);
      3'b001:  cond = (RS1VAL_MEM != RS2VAL_MEM);
      3'b100:  cond = ($signed(RS1VAL_MEM) <  $signed(RS2VAL_MEM));
      3'b101:  cond = ($signed(RS1VAL_MEM) >= $signed(RS2VAL_MEM));
      3'b110:  cond = (RS1VAL_MEM <  RS2VAL_MEM);
      3'b111:  cond = (RS1VAL_MEM >= RS2VAL_MEM);
      default: cond = 1'b0;
    endcase
  end

  assign take       = (BRANCH_MEM & cond) | JAL_MEM | JALR_MEM;
  assign jalr_sum   = RS1VAL_MEM + IMM_MEM;
  assign raw_target = JALR_MEM ? {jalr_sum[31:1], 1'b0} : (PC_MEM + IMM_MEM);
  assign misaligned = take & raw_target[1];
  assign lu = MEMREAD_EX && (RD_EX != 5'd0) &&
              ((USES_RS1_ID && (RS1_ID == RD_EX)) || (USES_RS2_ID && (RS2_ID == RD_EX)));

  // Redirect wins over any stall, including one already in progress.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    stall           = 1'b0;
    PCWrite         = 1'b1;
    IFID_WRITE      = 1'b1;
    BRANCHTAKEN_MEM = 1'b0;
    PC_N            = raw_target;
    IFID_FLUSH      = 1'b0;
    IDEX_FLUSH      = 1'b0;
    EXMEM_FLUSH     = 1'b0;
    if (take) begin
      state_nxt       = RUN;
      cnt_nxt         = 3'd0;
      BRANCHTAKEN_MEM = 1'b1;
      PC_N            = misaligned ? TRAP_VECTOR : raw_target;
      IFID_FLUSH      = 1'b1;
      IDEX_FLUSH      = 1'b1;
      EXMEM_FLUSH     = 1'b1;
    end else if (state == STALL) begin
      stall = 1'b1;
      if (cnt <= 3'd1) begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end else begin
        cnt_nxt = cnt - 3'd1;
      end
    end else if (lu) begin
      stall = 1'b1;
      if (LOAD_LATENCY > 1) begin
        state_nxt = STALL;
        cnt_nxt   = LAT_M1;
      end
    end
    if (stall) begin
      PCWrite    = 1'b0;
      IFID_WRITE = 1'b0;
      IDEX_FLUSH = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      cnt          <= 3'd0;
      TRAP         <= 1'b0;
      BADADDR      <= 32'd0;
      branch_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      TRAP  <= misaligned;
      if (misaligned) BADADDR <= raw_target;
      if (take) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign BRANCH_CNT = branch_cnt_q;
  assign STALL_CNT  = stall_cnt_q;

endmodule
